load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between core execute stage and data_memory; owns every data-memory access.
//  Word-aligns addresses and extracts/sign-extends LB/LH/LW/LBU/LHU load data.
//  data_memory writes whole words only, so SB/SH run as read-modify-write.
//  Flags misaligned or illegal requests without touching memory; 1-deep req/resp handshake.
// PARAMETERS
//  MEM_WORDS  16  words in data_memory; word index >= MEM_WORDS -> err, no access
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  reset_n         in   1   synchronous, active-low reset
//  req_valid       in   1   core presents request
//  req_ready       out  1   1 only in IDLE; request accepted when req_valid&&req_ready
//  req_is_load     in   1   load request
//  req_is_store    in   1   store request
//  req_funct3      in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, low bits used for B/H
//  resp_valid      out  1   one-cycle pulse, request complete
//  resp_rdata      out  32  extended load data, held until next resp_valid; 0 for stores/err
//  resp_err        out  1   valid with resp_valid: misaligned/illegal/out of range
//  mem_addr        out  32  {addr_q[31:2],2'b00}
//  mem_wdata       out  32  full word to write
//  mem_read_en     out  1   to data_memory.mem_read_en
//  mem_write_en    out  1   to data_memory.mem_write_en
//  mem_rdata       in   32  data_memory.read_data_out, combinational same-cycle
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0,
//   mem_* = 0. mem_read_en/mem_write_en also forced 0 combinationally while reset_n=0.
//  Accept in IDLE: latch is_load/is_store/funct3/addr/wdata into *_q regs.
//  Error check at accept: both or neither of is_load/is_store; load funct3 not in
//   {000,001,010,100,101}; store funct3 not in {000,001,010}; H with addr[0]=1;
//   W with addr[1:0]!=0; addr[31:2] >= MEM_WORDS. Any -> next state RESP, err=1.
//  FSM states and transitions:
//   IDLE    -> LOAD (load ok) | WRITE (SW ok) | RMW_RD (SB/SH ok) | RESP (err) | IDLE
//   LOAD    : mem_read_en=1; capture extract(mem_rdata,addr_q[1:0],funct3_q) -> RESP
//   RMW_RD  : mem_read_en=1; capture merge(mem_rdata,wdata_q,addr_q[1:0]) into wbuf -> WRITE
//   WRITE   : mem_write_en=1; mem_wdata = wdata_q (SW) or wbuf (SB/SH) -> RESP
//   RESP    : resp_valid=1 for exactly this cycle -> IDLE
//  Latency accept->resp_valid: err 1, LW/LB/LH/LBU/LHU 2, SW 2, SB/SH 3 cycles.
//  Throughput: next request accepted the cycle after RESP (IDLE); no pipelining.
//  Little-endian: byte k at bits [8k+7:8k]; half at addr[1] selects [15:0]/[31:16].
//  Extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W passthrough.
//  Merge: only addressed byte/half replaced, other bytes keep mem_rdata.
//  Enables are mutually exclusive; mem_addr=0 and enables 0 in IDLE/RESP.
//  req_* ignored outside IDLE. Reset mid-op: abort, no write issued, no resp_valid.
// STRUCTURE
//  lsu_defs.vh: funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU), state encodings.
//  Sub-module lsu_align (combinational): extract/extend for loads, byte/half merge
//   for stores; FSM, request regs and wbuf stay in load_store_unit.
//  Top ties data_memory.reset = ~reset_n.
// TESTING (word 0x8 preloaded 0x80FF7F01 unless noted)
//  LB 0x9 -> resp_rdata 0x0000007F; LB 0xB -> 0xFFFFFF80; resp_valid 2 cycles after accept.
//  LH 0xA -> 0xFFFF80FF; LHU 0xA -> 0x000080FF; LW 0x8 -> 0x80FF7F01.
//  SB 0xA wdata 0x123456AB -> one read, then one write 0x80AB7F01; resp at cycle 3; LW confirms.
//   SH 0x8 wdata 0xDEADBEEF on 0x80FF7F01 -> word 0x80FFBEEF.
//  LW 0x6, SH 0x9, funct3=011 store, addr 0x40 -> resp_err=1 at cycle 1, no mem enable ever high.
//  reset_n=0 during WRITE of SB -> word unchanged, resp_valid stays 0, req_ready=1 next cycle.
//  Back-to-back SW 0x4 0xCAFEF00D then LW 0x4 with req_valid held -> second accepted cycle after
//   first resp; returns 0xCAFEF00D, resp_err=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request-legality helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  function automatic logic f3_load_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_store_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] i_mem_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_mem_rdata[7:0];
    case (i_byte_off)
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      2'd3:    w_byte = i_mem_rdata[31:24];
      default: w_byte = i_mem_rdata[7:0];
    endcase
    w_half = i_byte_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  end

  always_comb begin
    o_load_data = i_mem_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_mem_rdata;
    endcase
  end

  always_comb begin
    o_merged = i_mem_rdata;
    case (i_funct3)
      F3_B: o_merged[{i_byte_off, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_byte_off[1]) o_merged[31:16] = i_wdata[15:0];
        else               o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: owns all data-memory traffic, aligns and extends loads,
// runs SB/SH as read-modify-write against a word-only memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  load_store_unit_if.slave  core,
  output logic [31:0]       o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_read_en,
  output logic              o_mem_write_en,
  output logic              o_mem_reset,
  input  logic [31:0]       i_mem_rdata
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_wbuf;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_err;
  logic        w_rd_en;
  logic        w_wr_en;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  lsu_align u_align (
    .i_mem_rdata (i_mem_rdata),
    .i_wdata     (r_wdata),
    .i_byte_off  (r_addr[1:0]),
    .i_funct3    (r_funct3),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  assign w_accept = core.req_valid && (r_state == ST_IDLE);

  always_comb begin
    w_req_err = 1'b0;
    if (core.req_is_load == core.req_is_store)                      w_req_err = 1'b1;
    if (core.req_is_load && !f3_load_ok(core.req_funct3))           w_req_err = 1'b1;
    if (core.req_is_store && !f3_store_ok(core.req_funct3))         w_req_err = 1'b1;
    if (f3_is_half(core.req_funct3) && core.req_addr[0])            w_req_err = 1'b1;
    if ((core.req_funct3 == F3_W) && (core.req_addr[1:0] != 2'b00)) w_req_err = 1'b1;
    if ({2'b00, core.req_addr[31:2]} >= MEM_WORDS)                  w_req_err = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (core.req_valid) begin
          if (w_req_err)                        w_state_nxt = ST_RESP;
          else if (core.req_is_load)            w_state_nxt = ST_LOAD;
          else if (core.req_funct3 == F3_W)     w_state_nxt = ST_WRITE;
          else                                  w_state_nxt = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        w_rd_en     = 1'b1;
        w_mem_addr  = {r_addr[31:2], 2'b00};
        w_state_nxt = ST_RESP;
      end
      ST_RMW_RD: begin
        w_rd_en     = 1'b1;
        w_mem_addr  = {r_addr[31:2], 2'b00};
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_wr_en     = 1'b1;
        w_mem_addr  = {r_addr[31:2], 2'b00};
        w_mem_wdata = (r_funct3 == F3_W) ? r_wdata : r_wbuf;
        w_state_nxt = ST_RESP;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // resp_rdata only changes on the edge entering RESP, so it holds between responses
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wbuf   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3 <= core.req_funct3;
        r_addr   <= core.req_addr;
        r_wdata  <= core.req_wdata;
        r_err    <= w_req_err;
        if (w_req_err) r_rdata <= '0;
      end
      if (r_state == ST_LOAD)   r_rdata <= w_load_data;
      if (r_state == ST_RMW_RD) r_wbuf  <= w_merged;
      if (r_state == ST_WRITE)  r_rdata <= '0;
    end
  end

  // Reset blocks the memory side combinationally so an in-flight write is never issued
  assign o_mem_read_en  = w_rd_en && i_reset_n;
  assign o_mem_write_en = w_wr_en && i_reset_n;
  assign o_mem_addr     = i_reset_n ? w_mem_addr  : '0;
  assign o_mem_wdata    = i_reset_n ? w_mem_wdata : '0;
  assign o_mem_reset    = ~i_reset_n;

  assign core.req_ready  = (r_state == ST_IDLE);
  assign core.resp_valid = (r_state == ST_RESP);
  assign core.resp_rdata = r_rdata;
  assign core.resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random bench for load_store_unit against a word-array memory
// and an arithmetic reference model of the load/store rules.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en, mem_reset;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  load_store_unit #(.MEM_WORDS(16)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .core           (bus),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_read_en  (mem_read_en),
    .o_mem_write_en (mem_write_en),
    .o_mem_reset    (mem_reset),
    .i_mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_we)            mem[pre_idx] <= pre_val;
    else if (mem_write_en) mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
    if (mem_read_en)  rd_cnt <= rd_cnt + 1;
    if (mem_write_en && mem_read_en) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output bit err, output logic [31:0] rd, output int lat,
                       output int nrd, output int nwr, output logic [31:0] new_word);
    int unsigned widx, boff;
    logic [31:0] word, mask;
    int v;
    widx = a / 4;
    boff = a % 4;
    err = (ld == st);
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) err = 1;
    if (st && !(f3 == 0 || f3 == 1 || f3 == 2)) err = 1;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) err = 1;
    if (f3 == 2 && (a % 4 != 0)) err = 1;
    if (widx >= 16) err = 1;
    rd = '0; lat = 1; nrd = 0; nwr = 0; new_word = '0;
    if (err) return;
    word = ref_mem[widx];
    new_word = word;
    if (ld) begin
      lat = 2; nrd = 1;
      case (f3)
        3'd0: begin v = int'((word >> (8 * boff)) & 32'd255);   if (v >= 128)   v -= 256;   rd = 32'(v); end
        3'd1: begin v = int'((word >> (8 * boff)) & 32'd65535); if (v >= 32768) v -= 65536; rd = 32'(v); end
        3'd4: rd = (word >> (8 * boff)) & 32'd255;
        3'd5: rd = (word >> (8 * boff)) & 32'd65535;
        default: rd = word;
      endcase
    end else begin
      nwr = 1;
      if (f3 == 2) begin
        lat = 2;
        new_word = wd;
      end else begin
        lat = 3; nrd = 1;
        mask = (f3 == 0) ? 32'd255 : 32'd65535;
        new_word = (word & ~(mask << (8 * boff))) | ((wd & mask) << (8 * boff));
      end
    end
  endtask

  task automatic run_op(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit e, seen;
    logic [31:0] r, nw;
    int lat, nrd, nwr, rd0, wr0, cyc;
    model(ld, st, f3, a, wd, e, r, lat, nrd, nwr, nw);
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin tick(); cyc++; end
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "/idle_addr"}, mem_addr, 32'd0);
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_is_load = ld; bus.req_is_store = st;
    bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
    cyc = 1; seen = 0;
    while (cyc <= 8) begin
      if (bus.resp_valid) begin seen = 1; break; end
      tick();
      cyc++;
    end
    chk({tag, "/resp_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, 32'(cyc), 32'(lat));
    chk({tag, "/err"}, 32'(bus.resp_err), 32'(e));
    chk({tag, "/rdata"}, bus.resp_rdata, r);
    chk({tag, "/reads"}, 32'(rd_cnt - rd0), 32'(nrd));
    chk({tag, "/writes"}, 32'(wr_cnt - wr0), 32'(nwr));
    last_rdata = bus.resp_rdata;
    last_err = bus.resp_err;
    if (!e && st) begin
      ref_mem[a / 4] = nw;
      chk({tag, "/memword"}, mem[a / 4], nw);
    end
    tick();
    chk({tag, "/pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    int wr0, cyc;
    logic [2:0] ldf [5];
    logic [2:0] stf [3];
    ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    stf = '{3'd0, 3'd1, 3'd2};

    bus.req_valid = 0; bus.req_is_load = 0; bus.req_is_store = 0;
    bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = (i == 2) ? 32'h80FF7F01 : $urandom;
      pre_we = 1'b1; pre_idx = 4'(i); pre_val = ref_mem[i];
      tick();
    end
    pre_we = 1'b0;
    tick();

    chk("rst/ready", 32'(bus.req_ready), 32'd1);
    chk("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst/rdata", bus.resp_rdata, 32'd0);
    chk("rst/err", 32'(bus.resp_err), 32'd0);
    chk("rst/rd_en", 32'(mem_read_en), 32'd0);
    chk("rst/wr_en", 32'(mem_write_en), 32'd0);
    chk("rst/addr", mem_addr, 32'd0);
    chk("rst/mem_reset", 32'(mem_reset), 32'd1);
    reset_n = 1'b1;
    tick();
    chk("run/mem_reset", 32'(mem_reset), 32'd0);

    run_op("LB9",  1, 0, 3'b000, 32'h9, 32'h0); chk("LB9/val",  last_rdata, 32'h0000007F);
    run_op("LBB",  1, 0, 3'b000, 32'hB, 32'h0); chk("LBB/val",  last_rdata, 32'hFFFFFF80);
    run_op("LHA",  1, 0, 3'b001, 32'hA, 32'h0); chk("LHA/val",  last_rdata, 32'hFFFF80FF);
    run_op("LHUA", 1, 0, 3'b101, 32'hA, 32'h0); chk("LHUA/val", last_rdata, 32'h000080FF);
    run_op("LW8",  1, 0, 3'b010, 32'h8, 32'h0); chk("LW8/val",  last_rdata, 32'h80FF7F01);
    run_op("SBA",  0, 1, 3'b000, 32'hA, 32'h123456AB);
    run_op("LW8b", 1, 0, 3'b010, 32'h8, 32'h0); chk("SBA/val",  last_rdata, 32'h80AB7F01);
    run_op("SW8",  0, 1, 3'b010, 32'h8, 32'h80FF7F01);
    run_op("SH8",  0, 1, 3'b001, 32'h8, 32'hDEADBEEF);
    run_op("LW8c", 1, 0, 3'b010, 32'h8, 32'h0); chk("SH8/val",  last_rdata, 32'h80FFBEEF);

    run_op("E_LW6",  1, 0, 3'b010, 32'h6,  32'h0); chk("E_LW6/flag",  32'(last_err), 32'd1);
    run_op("E_SH9",  0, 1, 3'b001, 32'h9,  32'h0); chk("E_SH9/flag",  32'(last_err), 32'd1);
    run_op("E_F3",   0, 1, 3'b011, 32'h0,  32'h0); chk("E_F3/flag",   32'(last_err), 32'd1);
    run_op("E_OOR",  1, 0, 3'b010, 32'h40, 32'h0); chk("E_OOR/flag",  32'(last_err), 32'd1);
    run_op("E_BOTH", 1, 1, 3'b010, 32'h0,  32'h0); chk("E_BOTH/flag", 32'(last_err), 32'd1);

    // reset while the SB write is on the bus
    saved = mem[2];
    wr0 = wr_cnt;
    bus.req_valid = 1; bus.req_is_load = 0; bus.req_is_store = 1;
    bus.req_funct3 = 3'b000; bus.req_addr = 32'hA; bus.req_wdata = 32'h55;
    tick();
    bus.req_valid = 0;
    tick();
    chk("rstmid/wr_active", 32'(mem_write_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstmid/wr_forced", 32'(mem_write_en), 32'd0);
    tick();
    chk("rstmid/ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid/resp_valid", 32'(bus.resp_valid), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid/no_resp", 32'(bus.resp_valid), 32'd0);
    end
    chk("rstmid/word", mem[2], saved);
    chk("rstmid/writes", 32'(wr_cnt - wr0), 32'd0);

    // back-to-back with req_valid held high
    bus.req_valid = 1; bus.req_is_load = 0; bus.req_is_store = 1;
    bus.req_funct3 = 3'b010; bus.req_addr = 32'h4; bus.req_wdata = 32'hCAFEF00D;
    tick();
    cyc = 1;
    while (!bus.resp_valid && cyc < 8) begin tick(); cyc++; end
    chk("b2b/sw_lat", 32'(cyc), 32'd2);
    bus.req_is_load = 1; bus.req_is_store = 0; bus.req_wdata = 32'h0;
    tick();
    chk("b2b/ready_after_resp", 32'(bus.req_ready), 32'd1);
    tick();
    chk("b2b/accepted", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 0;
    tick();
    chk("b2b/lw_valid", 32'(bus.resp_valid), 32'd1);
    chk("b2b/lw_data", bus.resp_rdata, 32'hCAFEF00D);
    chk("b2b/lw_err", 32'(bus.resp_err), 32'd0);
    ref_mem[1] = 32'hCAFEF00D;
    tick();

    for (int k = 0; k < 80; k++) begin
      int unsigned r;
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      ld = (r < 5);
      st = (r >= 5 && r < 9);
      if (r == 9) begin ld = 1'($urandom_range(0, 1)); st = ld; end
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld)                   f3 = ldf[$urandom_range(0, 4)];
      else                           f3 = stf[$urandom_range(0, 2)];
      a = 32'($urandom_range(0, 71));
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      run_op("RND", ld, st, f3, a, $urandom);
    end

    chk("excl/both_en", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
